mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store alignment stage between the EX/MEM pipeline register and the word-organised data memory. The data memory reads combinationally and writes whole 32-bit words on the clock edge.
- Converts RV32I loads (lb/lh/lw/lbu/lhu) into lane extraction with sign or zero extension.
- Converts stores: sw is a direct single-cycle write; sb/sh become a 2-cycle read-modify-write, with a pipeline stall for the first cycle.
- Detects misaligned and out-of-range accesses and suppresses their writes.

Parameters:
- MEM_BYTES, 8004, size of the data memory in bytes (2001 words); addr >= MEM_BYTES is out of range.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  memory op present in MEM stage
- req_write  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width/sign code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- addr  in  32  byte address from ALU
- wdata  in  32  store data (rs2), right-aligned
- stall  out  1  hold IF..MEM stages this cycle
- load_data  out  32  extended load result to MEM/WB
- fault  out  1  misaligned / out-of-range / illegal funct3 this cycle
- mem_adr  out  32  word-aligned address to data memory, {addr[31:2],2'b00}
- mem_wd  out  32  write word to data memory
- mem_write  out  1  data memory write enable
- mem_rd  in  32  combinational read word from data memory

Behaviour:
- FSM states: IDLE, RMW_WRITE. State register and merge_q[31:0] are flops; all outputs are combinational from state and inputs.
- Reset (async, rst_n=0): state=IDLE, merge_q=0. Outputs immediately: stall=0, mem_write=0, fault=0, mem_wd=0.
- Lane = addr[1:0].
- Misaligned: h/hu with addr[0]=1, or w with addr[1:0]!=0.
- Out of range: addr >= MEM_BYTES.
- Illegal: funct3 in {011,110,111}.
- fault = req_valid & (misaligned | out of range | illegal), evaluated in IDLE only.
- Faulted op: no write, load_data=0, stall=0, state stays IDLE.
- Load (IDLE, valid, !write, no fault): zero latency.
  - load_data = mem_rd lane bits, sign-extended for b/h and zero-extended for bu/hu; lw passes mem_rd unchanged.
  - stall=0, mem_write=0.
- sw (IDLE, no fault): same cycle mem_write=1, mem_wd=wdata, stall=0.
- sb/sh (IDLE, no fault):
  - Cycle 0: stall=1, mem_write=0. At the clock edge, merge_q <= mem_rd with wdata[7:0] or wdata[15:0] inserted at the lane; then state <= RMW_WRITE.
  - Cycle 1 (RMW_WRITE): mem_write=1, mem_wd=merge_q, stall=0, state <= IDLE.
  - The pipeline holds addr/funct3/wdata stable while stall=1. mem_adr is still driven from addr in RMW_WRITE.
- Byte-lane merge: byte k occupies bits [8k+7:8k]. Half at lane 0 uses [15:0]; half at lane 2 uses [31:16].
- req_valid=0 in IDLE: stall=0, mem_write=0, load_data=0, fault=0.
- In RMW_WRITE, req_valid and req_write are ignored; the op always completes. Back-to-back sub-word stores therefore take 2 cycles each.
- Reset asserted during RMW_WRITE: the write is abandoned and mem_write drops asynchronously; memory is unchanged.
- mem_wd = 0 whenever mem_write=0.

Test Plan:
- mem word @0x10 = 0x8899AABB; lb addr 0x13 -> load_data=0xFFFFFF88, stall=0; lbu 0x13 -> 0x00000088; lh 0x10 -> 0xFFFFAABB; lhu 0x12 -> 0x00008899.
- sw addr 0x20 wdata 0xDEADBEEF -> same cycle mem_write=1, mem_adr=0x20, mem_wd=0xDEADBEEF, stall=0; a subsequent lw of 0x20 returns 0xDEADBEEF.
- word @0x30 = 0x11223344; sb addr 0x31 wdata 0x000000AA:
  - Cycle 0: stall=1, mem_write=0.
  - Cycle 1: mem_write=1, mem_wd=0x1122AA44.
  - Memory then reads 0x1122AA44.
- sh addr 0x32 wdata 0x0000CAFE over word 0x11223344 -> mem_wd=0xCAFE3344 in cycle 1. A back-to-back second sh to 0x30 takes 2 more cycles, with stall high for exactly 1 of them.
- Faults, each -> fault=1, mem_write=0, stall=0, memory unchanged:
  - sw addr 0x22
  - lh addr 0x11
  - lw addr 0x00002000 (>= 8004)
  - funct3=011
- rst_n pulled low in RMW_WRITE of sb 0x30 -> mem_write falls before the next edge, state IDLE, word @0x30 unchanged, stall=0 after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: RV32I load/store alignment between EX/MEM and a word-organised data memory.
// Sub-word stores are a 2-cycle read-modify-write; sw and all loads are single-cycle.
module mem_access_unit #(
    parameter int unsigned MEM_BYTES = 8004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        fault,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wd,
    output logic        mem_write,
    input  logic [31:0] mem_rd
);
    typedef enum logic {IDLE, RMW_WRITE} state_t;
    state_t      state, state_nx;
    logic [31:0] merge_q, merged, mask, rd_sh, ld_ext;
    logic [4:0]  shift;
    logic        is_h, is_w, sgn, illegal, misal, oor, bad;
    assign is_h    = funct3[1:0] == 2'b01;
    assign is_w    = funct3 == 3'b010;
    assign sgn     = ~funct3[2];
    assign illegal = funct3 == 3'b011 || funct3[2:1] == 2'b11;
    assign misal   = (is_h & addr[0]) | (is_w & |addr[1:0]);
    assign oor     = addr >= MEM_BYTES;
    assign bad     = illegal | misal | oor;
    assign mem_adr = {addr[31:2], 2'b00};
    assign shift   = {addr[1:0], 3'b000};
    assign rd_sh   = mem_rd >> shift;
    assign ld_ext  = is_w ? mem_rd
                   : is_h ? {{16{sgn & rd_sh[15]}}, rd_sh[15:0]}
                   : {{24{sgn & rd_sh[7]}}, rd_sh[7:0]};
    // Halfwords are aligned here, so a lane shift of 0 or 16 places them correctly
    assign mask    = (is_h ? 32'h0000_ffff : 32'h0000_00ff) << shift;
    assign merged  = (mem_rd & ~mask) | ((wdata << shift) & mask);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            merge_q <= '0;
        end else begin
            state   <= state_nx;
            merge_q <= stall ? merged : merge_q;
        end
    end
    always_comb begin
        state_nx  = state;
        stall     = 1'b0;
        mem_write = 1'b0;
        mem_wd    = '0;
        load_data = '0;
        fault     = 1'b0;
        if (state == RMW_WRITE) begin
            mem_write = 1'b1;
            mem_wd    = merge_q;
            state_nx  = IDLE;
        end else if (req_valid) begin
            fault = bad;
            if (!bad && req_write && is_w) begin
                mem_write = 1'b1;
                mem_wd    = wdata;
            end else if (!bad && req_write) begin
                stall    = 1'b1;
                state_nx = RMW_WRITE;
            end else if (!bad) begin
                load_data = ld_ext;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of loads, sw, sub-word RMW stores, faults and reset-abort.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        stall, fault, mem_write;
    logic [31:0] load_data, mem_adr, mem_wd, mem_rd;
    logic [31:0] mem [0:2000];
    logic        pre_we;
    logic [31:0] pre_adr, pre_dat;
    int          total = 0;
    int          passed = 0;
    int          stalls;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
        .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
        .load_data(load_data), .fault(fault), .mem_adr(mem_adr), .mem_wd(mem_wd),
        .mem_write(mem_write), .mem_rd(mem_rd)
    );

    assign mem_rd = (mem_adr < 32'd8004) ? mem[mem_adr[12:2]] : '0;

    always @(posedge clk) begin
        if (mem_write) mem[mem_adr[12:2]] <= mem_wd;
        else if (pre_we) mem[pre_adr[12:2]] <= pre_dat;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h", tag, got, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic v, input logic w, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] d);
        req_valid = v;
        req_write = w;
        funct3    = f;
        addr      = a;
        wdata     = d;
        #1;
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pre_adr = a;
        pre_dat = d;
        pre_we  = 1'b1;
        tick();
        pre_we  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        pre_we = 1'b0;
        pre_adr = '0;
        pre_dat = '0;
        op(0, 0, 3'b000, 32'h0, 32'h0);
        #2;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        tick();
        rst_n = 1'b1;
        preload(32'h10, 32'h8899aabb);
        preload(32'h30, 32'h11223344);
        preload(32'h20, 32'h0);

        op(1, 0, 3'b000, 32'h13, 32'h0);
        chk("lb_13", load_data, 32'hffffff88);
        chk("lb_13_stall", 32'(stall), 32'd0);
        op(1, 0, 3'b100, 32'h13, 32'h0);
        chk("lbu_13", load_data, 32'h00000088);
        op(1, 0, 3'b001, 32'h10, 32'h0);
        chk("lh_10", load_data, 32'hffffaabb);
        op(1, 0, 3'b101, 32'h12, 32'h0);
        chk("lhu_12", load_data, 32'h00008899);
        op(1, 0, 3'b000, 32'h10, 32'h0);
        chk("lb_10", load_data, 32'hffffffbb);
        op(1, 0, 3'b010, 32'h10, 32'h0);
        chk("lw_10", load_data, 32'h8899aabb);
        op(0, 0, 3'b010, 32'h10, 32'h0);
        chk("idle_load_data", load_data, 32'h0);
        chk("idle_fault", 32'(fault), 32'd0);

        tick();
        op(1, 1, 3'b010, 32'h20, 32'hdeadbeef);
        chk("sw_mem_write", 32'(mem_write), 32'd1);
        chk("sw_mem_adr", mem_adr, 32'h20);
        chk("sw_mem_wd", mem_wd, 32'hdeadbeef);
        chk("sw_stall", 32'(stall), 32'd0);
        tick();
        op(1, 0, 3'b010, 32'h20, 32'h0);
        chk("lw_after_sw", load_data, 32'hdeadbeef);

        tick();
        op(1, 1, 3'b000, 32'h31, 32'h000000aa);
        chk("sb_c0_stall", 32'(stall), 32'd1);
        chk("sb_c0_mem_write", 32'(mem_write), 32'd0);
        tick();
        chk("sb_c1_mem_write", 32'(mem_write), 32'd1);
        chk("sb_c1_mem_wd", mem_wd, 32'h1122aa44);
        chk("sb_c1_stall", 32'(stall), 32'd0);
        chk("sb_c1_mem_adr", mem_adr, 32'h30);
        req_valid = 1'b0;
        tick();
        chk("sb_mem_word", mem[12], 32'h1122aa44);
        op(1, 0, 3'b010, 32'h30, 32'h0);
        chk("sb_lw_back", load_data, 32'h1122aa44);

        req_valid = 1'b0;
        preload(32'h30, 32'h11223344);
        op(1, 1, 3'b001, 32'h32, 32'h0000cafe);
        chk("sh1_c0_stall", 32'(stall), 32'd1);
        tick();
        chk("sh1_c1_mem_write", 32'(mem_write), 32'd1);
        chk("sh1_c1_mem_wd", mem_wd, 32'hcafe3344);
        tick();
        stalls = 0;
        op(1, 1, 3'b001, 32'h30, 32'h0000beef);
        stalls += int'(stall);
        chk("sh2_c0_mem_write", 32'(mem_write), 32'd0);
        tick();
        stalls += int'(stall);
        chk("sh2_c1_mem_write", 32'(mem_write), 32'd1);
        chk("sh2_c1_mem_wd", mem_wd, 32'hcafebeef);
        chk("sh2_stall_cycles", 32'(stalls), 32'd1);
        req_valid = 1'b0;
        tick();
        chk("sh2_mem_word", mem[12], 32'hcafebeef);

        op(1, 1, 3'b010, 32'h22, 32'h12345678);
        chk("f_sw22_fault", 32'(fault), 32'd1);
        chk("f_sw22_mem_write", 32'(mem_write), 32'd0);
        chk("f_sw22_stall", 32'(stall), 32'd0);
        tick();
        chk("f_sw22_mem", mem[8], 32'hdeadbeef);
        op(1, 1, 3'b000, 32'h2000, 32'h000000ff);
        chk("f_sb_oor_fault", 32'(fault), 32'd1);
        chk("f_sb_oor_stall", 32'(stall), 32'd0);
        op(1, 0, 3'b001, 32'h11, 32'h0);
        chk("f_lh11_fault", 32'(fault), 32'd1);
        chk("f_lh11_load_data", load_data, 32'h0);
        op(1, 0, 3'b010, 32'h2000, 32'h0);
        chk("f_lw_oor_fault", 32'(fault), 32'd1);
        op(1, 0, 3'b010, 32'd8000, 32'h0);
        chk("lw_last_word_fault", 32'(fault), 32'd0);
        op(1, 1, 3'b011, 32'h10, 32'h0);
        chk("f_illegal_fault", 32'(fault), 32'd1);
        chk("f_illegal_mem_write", 32'(mem_write), 32'd0);
        tick();
        chk("f_mem10", mem[4], 32'h8899aabb);
        chk("f_mem30", mem[12], 32'hcafebeef);

        req_valid = 1'b0;
        preload(32'h30, 32'h11223344);
        op(1, 1, 3'b000, 32'h30, 32'h00000055);
        tick();
        chk("rst_rmw_mem_write", 32'(mem_write), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_rmw_drop", 32'(mem_write), 32'd0);
        chk("rst_rmw_mem_wd", mem_wd, 32'h0);
        req_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_rmw_stall", 32'(stall), 32'd0);
        chk("rst_rmw_idle", 32'(mem_write), 32'd0);
        chk("rst_rmw_mem", mem[12], 32'h11223344);
        op(1, 0, 3'b010, 32'h30, 32'h0);
        chk("rst_rmw_lw", load_data, 32'h11223344);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
